// File: rtl/z3_target_ctrl.sv
// Zorro III target-side bus cycle controller: decodes the board/autoconfig space,
// selects a slave region and sequences DTACK/BERR/MTACK terminations including bursts.
module z3_target_ctrl #(
  parameter int NUM_REGIONS    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                     CLK,
  input  logic                     IORST_n,
  input  logic                     FCS_n,
  input  logic [3:0]               DS_n,
  input  logic                     MTCR_n,
  input  logic [31:2]              A,
  input  logic [2:0]               FC,
  input  logic                     READ,
  input  logic                     DOE,
  input  logic [3:0]               board_base,
  input  logic                     configured,
  input  logic                     cfgin_n,
  input  logic                     shutup,
  input  logic [8*NUM_REGIONS-1:0] region_lo,
  input  logic [8*NUM_REGIONS-1:0] region_hi,
  input  logic [NUM_REGIONS-1:0]   region_ro,
  input  logic [NUM_REGIONS-1:0]   region_burst,
  input  logic [NUM_REGIONS-1:0]   region_ack,
  output logic [NUM_REGIONS-1:0]   region_req,
  output logic [23:2]              cyc_addr,
  output logic                     cyc_write,
  output logic [3:0]               cyc_be,
  output logic [7:0]               beat,
  output logic                     acfg_sel,
  output logic                     DTACK,
  output logic                     BERR,
  output logic                     MTACK
);

  typedef enum logic [2:0] {IDLE, START, DATA, ACK, BWAIT, ERR} state_t;

  localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [9:0] TIMEOUT_VAL = 10'(TIMEOUT_CYCLES);

  state_t                        state, state_nxt;
  logic [SYNC_STAGES-1:0]        fcs_sync, mtcr_sync, flush_q;
  logic [SYNC_STAGES-1:0][3:0]   ds_sync;
  logic                          armed_q;
  logic                          fcs_s, mtcr_s, ds_any, ds_none;
  logic [3:0]                    ds_s;
  logic [31:8]                   addr_hi;
  logic [7:2]                    addr_lo;
  logic                          board_match, acfg_match, valid_space;
  logic                          hit_d, hit_q, acfg_q;
  logic [SEL_W-1:0]              sel_d, sel_q;
  logic                          cur_hit, cur_acfg;
  logic [SEL_W-1:0]              cur_sel;
  logic [9:0]                    tcnt, tcnt_inc;
  logic                          enter_data, in_cycle;
  logic [NUM_REGIONS-1:0]        req_nxt;
  logic                          mtack_nxt, acfg_nxt;
  logic                          unused_ok;

  // Strobe synchronizers idle high. A new cycle is only accepted once the chain
  // has flushed and FCS_n has really been seen high, so a cycle straddling reset is dropped.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      fcs_sync  <= '1;
      mtcr_sync <= '1;
      ds_sync   <= '1;
      flush_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      fcs_sync  <= {fcs_sync[SYNC_STAGES-2:0], FCS_n};
      mtcr_sync <= {mtcr_sync[SYNC_STAGES-2:0], MTCR_n};
      ds_sync   <= {ds_sync[SYNC_STAGES-2:0], DS_n};
      flush_q   <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      armed_q   <= armed_q | (flush_q[SYNC_STAGES-1] & fcs_s);
    end
  end

  assign fcs_s   = fcs_sync[SYNC_STAGES-1];
  assign mtcr_s  = mtcr_sync[SYNC_STAGES-1];
  assign ds_s    = ds_sync[SYNC_STAGES-1];
  assign ds_any  = (ds_s != 4'hF);
  assign ds_none = (ds_s == 4'hF);
  assign cyc_be  = ~ds_s;

  // The upper address is multiplexed with data, so it is held from the FCS_n edge itself.
  always_ff @(negedge FCS_n or negedge IORST_n) begin
    if (!IORST_n) addr_hi <= '0;
    else          addr_hi <= A[31:8];
  end

  assign board_match = (addr_hi[31:28] == board_base) && configured;
  assign acfg_match  = (addr_hi[31:24] == 8'hFF) && !configured && !shutup && !cfgin_n;
  assign valid_space = FC[1] ^ FC[0];
  assign unused_ok   = &{1'b0, FC[2]};

  always_comb begin
    hit_d = 1'b0;
    sel_d = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (addr_hi[23:16] >= region_lo[8*i +: 8] && addr_hi[23:16] <= region_hi[8*i +: 8]) begin
        hit_d = 1'b1;
        sel_d = SEL_W'(i);
      end
    end
  end

  assign cur_hit  = (state == IDLE) ? hit_d      : hit_q;
  assign cur_acfg = (state == IDLE) ? acfg_match : acfg_q;
  assign cur_sel  = (state == IDLE) ? sel_d      : sel_q;
  assign tcnt_inc = tcnt + 10'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fcs_s && armed_q && (board_match || acfg_match) && valid_space) state_nxt = START;
      START: begin
        if (!acfg_q && (!hit_q || (cyc_write && region_ro[sel_q]))) state_nxt = ERR;
        else if (!cyc_write || (ds_any && DOE))                     state_nxt = DATA;
      end
      DATA: begin
        if (region_ack[sel_q])              state_nxt = ACK;
        else if (tcnt_inc == TIMEOUT_VAL)   state_nxt = ERR;
      end
      ACK:   if (MTACK && ds_none) state_nxt = BWAIT;
      BWAIT: if (ds_any)           state_nxt = DATA;
      ERR:   state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
    if (fcs_s) state_nxt = IDLE;
  end

  assign enter_data = (state_nxt == DATA) && (state != DATA);
  assign in_cycle   = state_nxt inside {START, DATA, ACK, BWAIT};

  always_comb begin
    req_nxt = '0;
    if (state_nxt == DATA) req_nxt[sel_q] = 1'b1;
    mtack_nxt = in_cycle && !cur_acfg && cur_hit && region_burst[cur_sel] && !mtcr_s;
    acfg_nxt  = cur_acfg && (state_nxt inside {START, DATA, ACK});
  end

  // Outputs are registered from the next state so terminations never glitch on decode.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      state      <= IDLE;
      sel_q      <= '0;
      hit_q      <= 1'b0;
      acfg_q     <= 1'b0;
      cyc_write  <= 1'b0;
      tcnt       <= '0;
      beat       <= '0;
      addr_lo    <= '0;
      region_req <= '0;
      DTACK      <= 1'b0;
      BERR       <= 1'b0;
      MTACK      <= 1'b0;
      acfg_sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == START) begin
        sel_q     <= acfg_match ? '0 : sel_d;
        hit_q     <= hit_d;
        acfg_q    <= acfg_match;
        cyc_write <= !READ;
        beat      <= '0;
      end
      if (enter_data) begin
        tcnt    <= '0;
        addr_lo <= A[7:2];
        if (state == BWAIT && beat != 8'hFF) beat <= beat + 8'd1;
      end else if (state == DATA) begin
        tcnt <= tcnt_inc;
      end
      region_req <= req_nxt;
      DTACK      <= (state_nxt == ACK);
      BERR       <= (state_nxt == ERR);
      MTACK      <= mtack_nxt;
      acfg_sel   <= acfg_nxt;
    end
  end

  assign cyc_addr = {addr_hi[23:8], addr_lo};

endmodule
